nios2_mult_seq: RTL

- Multiply sequencer sitting directly upstream of the 32x16 multiply cell (`cell_result = src1 * src2[15:0] mod 2^32`, registered inside the cell).
- Accepts a full 32x32 multiply request, drives the cell over one or two passes (low half of src2, then high half), and accumulates the passes into the low 32 bits of the product.
- Returns the product to the CPU result mux over a valid/ready response handshake.

---
 rtl/nios2_mult_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/nios2_mult_seq.sv
// Multiply sequencer for a 32x16 multiply cell.
// Splits a 32x32 request into one or two cell passes (low half, then high half
// of src2), sums the partial products into the low 32 bits of the product and
// returns them over a response handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. req_ready is high only in IDLE; rsp_valid is high only in DONE and
// rsp_valid/rsp_result stay constant until the transfer edge.
module nios2_mult_seq #(
  parameter int CELL_LATENCY = 1,
  parameter bit SKIP_ZERO_HI = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  input  logic [31:0] cell_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter reload value: the cell result is sampled once the counter has
  // run down to zero, CELL_LATENCY+1 edges after the operands change.
  localparam logic [1:0] LAT = 2'(CELL_LATENCY);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic [31:0] b_q;
  logic [31:0] acc;
  logic        accept;
  logic        capture;
  logic        skip_hi;

  // Ready is held low while reset is asserted, even though state is IDLE.
  assign req_ready = (state == IDLE) && reset_n;
  assign accept    = req_valid && req_ready;
  assign capture   = (cnt == 2'd0);
  assign skip_hi   = SKIP_ZERO_HI && (b_q[31:16] == 16'h0000);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; requests outside IDLE are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept)    state_nxt = PASS1;
      PASS1: if (capture)   state_nxt = skip_hi ? DONE : PASS2;
      PASS2: if (capture)   state_nxt = DONE;
      DONE:  if (rsp_ready) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Operand latch, pass counter, partial-product accumulation and result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 2'd0;
      b_q        <= 32'h0;
      acc        <= 32'h0;
      rsp_result <= 32'h0;
      cell_src1  <= 32'h0;
      cell_src2  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            b_q       <= req_src2;
            cell_src1 <= req_src1;
            cell_src2 <= {16'h0, req_src2[15:0]};
            cnt       <= LAT;
          end
        end
        PASS1: begin
          if (capture) begin
            acc <= cell_result;
            cnt <= LAT;
            // Low-half product is already the full answer when the high
            // half of the multiplier is zero and skipping is enabled.
            if (skip_hi) rsp_result <= cell_result;
            else         cell_src2  <= {16'h0, b_q[31:16]};
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        PASS2: begin
          if (capture) begin
            // Only the low 16 bits of the high-half product land in [31:16].
            rsp_result <= acc + {cell_result[15:0], 16'h0};
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
